tour_cmd_seq: RTL
=================

// Module: tour_cmd_seq
// PURPOSE
//  Sequences a solved knight's tour into cmd_proc. Each tour move becomes two cmd_proc
//  commands: a vertical leg (2 or 1 squares), then a horizontal leg (1 or 2 squares).
//  Outside a tour it passes UART_wrapper commands straight through to cmd_proc.
//  Sits between UART_wrapper/tour solver (upstream) and cmd_proc (downstream).
// PARAMETERS
//  NUM_MOVES  24  moves per tour (5x5 board); mv_indx counts 0..NUM_MOVES-1
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   asynchronous active-low reset
//  start_tour      in   1   1-clk pulse from solver: tour solved, begin sequencing
//  move            in   8   one-hot move at mv_indx (solver memory, combinational read)
//  mv_indx         out  5   index of current tour move
//  cmd_UART        in   16  command from UART_wrapper
//  cmd_rdy_UART    in   1   UART command valid
//  clr_cmd_rdy     in   1   cmd_proc consumed cmd
//  clr_cmd_rdy_UART out 1   clr_cmd_rdy forwarded to UART_wrapper (IDLE only)
//  send_resp       in   1   cmd_proc finished current command
//  cmd             out  16  command to cmd_proc
//  cmd_rdy         out  1   command valid to cmd_proc
//  resp            out  8   response byte to UART_wrapper
//  tour_err        out  1   sticky: illegal move encoding seen
// BEHAVIOUR
//  Cmd format: [15:12] opcode (4'h2 move, 4'h3 move+fanfare), [11:4] heading,
//   [3:0] squares. Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
//  move decode (dy,dx): b0(+2,+1) b1(+2,-1) b2(-1,-2) b3(+1,-2) b4(-2,-1) b5(-2,+1)
//   b6(+1,+2) b7(-1,+2). +y=N, +x=E. Vertical leg opcode 4'h2; horizontal opcode 4'h3.
//   Example: b0 -> 16'h2002 then 16'h3BF1.
//  Reset: state IDLE, mv_indx=0, tour_err=0. In IDLE after reset: cmd=cmd_UART,
//   cmd_rdy=cmd_rdy_UART, resp=8'hA5.
//  FSM:
//   IDLE:  pass-through. clr_cmd_rdy_UART=clr_cmd_rdy. start_tour -> VERT, mv_indx=0.
//          start_tour has priority over a coincident cmd_rdy_UART: the UART cmd stays
//          pending in the wrapper.
//   VERT:  cmd=vertical leg, cmd_rdy=1. On clr_cmd_rdy -> VWAIT (cmd_rdy drops next clk).
//   VWAIT: cmd_rdy=0. On send_resp -> HORZ.
//   HORZ:  cmd=horizontal leg, cmd_rdy=1. On clr_cmd_rdy -> HWAIT.
//   HWAIT: cmd_rdy=0. On send_resp:
//          - if mv_indx==NUM_MOVES-1: -> IDLE, mv_indx=0.
//          - else: mv_indx++, -> VERT.
//  Outside IDLE, clr_cmd_rdy_UART=0. cmd_UART and cmd_rdy_UART are ignored.
//  resp: 8'h5A while in VERT..HWAIT and mv_indx<NUM_MOVES-1; otherwise 8'hA5.
//   Only the final move's send_resp and UART commands return 8'hA5.
//  Illegal move (zero or multiple bits set), sampled on entry to VERT:
//   set tour_err, -> IDLE, mv_indx=0, no cmd_rdy issued. tour_err clears only on reset.
//  send_resp in VERT/HORZ (before clr_cmd_rdy) is ignored.
//  start_tour outside IDLE is ignored.
//  Async reset mid-tour: immediate return to IDLE; cmd_rdy drops without a handshake.
//  cmd and resp are combinational from state/mv_indx/move.
//  mv_indx and state are registered. No wrap beyond NUM_MOVES-1.
// STRUCTURE
//  Package tour_pkg: state enum (IDLE,VERT,VWAIT,HORZ,HWAIT); opcode constants
//   MOVE=4'h2, MOVE_FF=4'h3; heading constants HDG_N/W/S/E; resp constants
//   RESP_DONE=8'hA5, RESP_ACK=8'h5A.
//  Sub-module move_decode: one-hot move -> {vert_cmd, horz_cmd, illegal}. Pure combinational.
// TESTING
//  1. IDLE pass-through: cmd_UART=16'h2001 with cmd_rdy_UART=1 -> cmd=16'h2001,
//     cmd_rdy=1; clr_cmd_rdy is echoed on clr_cmd_rdy_UART; resp=8'hA5.
//  2. start_tour with move=8'h01 -> cmd=16'h2002, cmd_rdy=1.
//     After clr_cmd_rdy and send_resp -> cmd=16'h3BF1.
//     Second send_resp -> mv_indx=1.
//  3. Full tour: NUM_MOVES=24 moves of 8'h40 with a cmd_proc handshake model
//     -> 48 commands issued; resp=8'h5A for moves 0..22 and 8'hA5 on the last;
//     ends in IDLE with mv_indx=0.
//  4. Illegal move=8'h03 at mv_indx=3 -> tour_err=1, no cmd_rdy, back to IDLE.
//     UART pass-through works afterwards.
//  5. start_tour coincident with cmd_rdy_UART -> tour vertical cmd is issued and
//     clr_cmd_rdy_UART stays 0. Early send_resp in VERT leaves state unchanged.
//  6. rst_n low during HWAIT at mv_indx=10 -> cmd_rdy=0, mv_indx=0, IDLE, tour_err=0
//     immediately, asynchronously.

Source files
------------

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's tour command sequencer.
// Opcodes, headings, response bytes and the sequencer state encoding.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    VWAIT,
    HORZ,
    HWAIT
  } state_t;

  localparam logic [3:0] MOVE    = 4'h2;
  localparam logic [3:0] MOVE_FF = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;

  function automatic logic [15:0] mk_cmd(
    input logic [3:0] op,
    input logic [7:0] hdg,
    input logic [3:0] sq
  );
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/tour_cmd_seq_move_decode.sv
// One-hot knight move to a vertical and a horizontal cmd_proc command.
// Zero or multiple bits set flags the move as illegal.
module move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        illegal
);

  logic       south;
  logic       west;
  logic [3:0] vsq;
  logic [3:0] hsq;

  assign illegal = !$onehot(move);

  // Split the move into signed vertical and horizontal components.
  always_comb begin
    south = 1'b0;
    west  = 1'b0;
    vsq   = 4'd0;
    hsq   = 4'd0;
    if (!illegal) begin
      unique case (1'b1)
        move[0]: begin south = 1'b0; vsq = 4'd2; west = 1'b0; hsq = 4'd1; end
        move[1]: begin south = 1'b0; vsq = 4'd2; west = 1'b1; hsq = 4'd1; end
        move[2]: begin south = 1'b1; vsq = 4'd1; west = 1'b1; hsq = 4'd2; end
        move[3]: begin south = 1'b0; vsq = 4'd1; west = 1'b1; hsq = 4'd2; end
        move[4]: begin south = 1'b1; vsq = 4'd2; west = 1'b1; hsq = 4'd1; end
        move[5]: begin south = 1'b1; vsq = 4'd2; west = 1'b0; hsq = 4'd1; end
        move[6]: begin south = 1'b0; vsq = 4'd1; west = 1'b0; hsq = 4'd2; end
        move[7]: begin south = 1'b1; vsq = 4'd1; west = 1'b0; hsq = 4'd2; end
        default: ;
      endcase
    end
  end

  assign vert_cmd = mk_cmd(MOVE, south ? HDG_S : HDG_N, vsq);
  assign horz_cmd = mk_cmd(MOVE_FF, west ? HDG_W : HDG_E, hsq);

endmodule

// File: rtl/tour_cmd_seq.sv
// Feeds a solved knight's tour to cmd_proc as vertical/horizontal legs,
// and passes UART commands straight through when no tour is running.
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  output logic        clr_cmd_rdy_UART,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp,
  output logic        tour_err
);

  localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] idx_nxt;
  logic       err_nxt;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic        illegal;

  move_decode u_dec (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .illegal  (illegal)
  );

  // State, move index and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mv_indx  <= 5'd0;
      tour_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      mv_indx  <= idx_nxt;
      tour_err <= err_nxt;
    end
  end

  // Next state and command mux; UART path only owns cmd_proc in IDLE.
  always_comb begin
    state_nxt        = state;
    idx_nxt          = mv_indx;
    err_nxt          = tour_err;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    unique case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        if (start_tour) begin
          state_nxt = VERT;
          idx_nxt   = 5'd0;
        end
      end
      VERT: begin
        cmd = vert_cmd;
        if (illegal) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          idx_nxt   = 5'd0;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) state_nxt = VWAIT;
        end
      end
      VWAIT: begin
        cmd = vert_cmd;
        if (send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = HWAIT;
      end
      HWAIT: begin
        cmd = horz_cmd;
        if (send_resp) begin
          if (mv_indx == LAST) begin
            state_nxt = IDLE;
            idx_nxt   = 5'd0;
          end else begin
            state_nxt = VERT;
            idx_nxt   = mv_indx + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Acknowledge mid-tour; the last move and UART traffic report done.
  always_comb begin
    resp = RESP_DONE;
    if (state != IDLE && mv_indx < LAST) resp = RESP_ACK;
  end

endmodule
